// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller (load-use stall, branch redirect/flush, external halt)
//
// Optional feature macro: HAZARD_CTRL_PERF_EN adds saturating stall/flush counters.
//
// Ports:
//   clk              single clock, rising edge
//   rst              synchronous active-high reset
//   i_d_rs1/i_d_rs2  decode-stage source registers
//   i_ex_rd          execute-stage destination register
//   i_ex_memrd       execute-stage instruction is a load
//   i_ex_br_taken    execute stage resolved a taken branch/jump
//   i_ex_br_target   redirect target word address
//   i_halt_req       external hold request
//   o_f_pcwr         fetch hold (PC and fetch outputs frozen)
//   o_f_pcsrc        fetch redirect strobe
//   o_f_pc_in        redirect target while o_f_pcsrc=1, else 0
//   o_d_flush        kill the fetch/decode register
//   o_e_bubble       insert a NOP into execute
//   o_stall_cnt      (HAZARD_CTRL_PERF_EN) cycles with o_f_pcwr=1, saturating
//   o_flush_cnt      (HAZARD_CTRL_PERF_EN) cycles with o_f_pcsrc=1, saturating
module hazard_ctrl #(
    parameter int LU_STALL = 1,
    parameter int XLEN_PC  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         i_d_rs1,
    input  logic [4:0]         i_d_rs2,
    input  logic [4:0]         i_ex_rd,
    input  logic               i_ex_memrd,
    input  logic               i_ex_br_taken,
    input  logic [XLEN_PC-1:0] i_ex_br_target,
    input  logic               i_halt_req,
    output logic               o_f_pcwr,
    output logic               o_f_pcsrc,
    output logic [XLEN_PC-1:0] o_f_pc_in,
    output logic               o_d_flush,
    output logic               o_e_bubble
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [15:0]        o_stall_cnt,
    output logic [15:0]        o_flush_cnt
`endif
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_t;

    localparam logic [1:0] LU_M1 = 2'(LU_STALL - 1);

    state_t     r_state, w_nstate;
    logic [1:0] r_scnt, w_nscnt;
    logic       w_hit;

    assign w_hit = i_ex_memrd && (i_ex_rd != 5'd0) && (i_ex_rd == i_d_rs1 || i_ex_rd == i_d_rs2);

    // HALT with halt_req released behaves like RUN in that same cycle, so a
    // load-use hazard present at release is caught without extra latency.
    // A FLUSH cycle that coincides with a halt still kills the decode slot.
    always_comb begin
        o_f_pcwr   = 1'b0;
        o_f_pcsrc  = 1'b0;
        o_f_pc_in  = '0;
        o_d_flush  = 1'b0;
        o_e_bubble = 1'b0;
        w_nstate   = RUN;
        w_nscnt    = 2'd0;
        if (rst) begin
            w_nstate = RUN;
        end else if (i_ex_br_taken) begin
            o_f_pcsrc = 1'b1;
            o_f_pc_in = i_ex_br_target;
            o_d_flush = 1'b1;
            w_nstate  = FLUSH;
        end else if (i_halt_req) begin
            o_f_pcwr   = 1'b1;
            o_e_bubble = 1'b1;
            o_d_flush  = (r_state == FLUSH);
            w_nstate   = HALT;
        end else if (r_state == FLUSH) begin
            o_d_flush  = 1'b1;
            o_e_bubble = 1'b1;
        end else if (r_state == STALL) begin
            o_f_pcwr   = 1'b1;
            o_e_bubble = 1'b1;
            w_nscnt    = (r_scnt == 2'd0) ? 2'd0 : r_scnt - 2'd1;
            w_nstate   = (r_scnt > 2'd1) ? STALL : RUN;
        end else if (w_hit) begin
            o_f_pcwr   = 1'b1;
            o_e_bubble = 1'b1;
            w_nscnt    = LU_M1;
            w_nstate   = (LU_STALL > 1) ? STALL : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_scnt  <= 2'd0;
        end else begin
            r_state <= w_nstate;
            r_scnt  <= w_nscnt;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (o_f_pcwr && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (o_f_pcsrc && r_flush_cnt != 16'hFFFF)
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus random checks of hazard_ctrl (LU_STALL=1 and 3) against a cycle-budget model
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  d_rs1 = '0, d_rs2 = '0, ex_rd = '0;
    logic        ex_memrd = 1'b0, ex_br_taken = 1'b0, halt_req = 1'b0;
    logic [11:0] ex_br_target = '0;
    logic [1:0]  pcwr, pcsrc, dfl, bub;
    logic [11:0] pcin [2];
`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] scnt [2];
    logic [15:0] fcnt [2];
    int          m_scnt [2] = '{0, 0};
    int          m_fcnt [2] = '{0, 0};
`endif

    int checks = 0;
    int errors = 0;

    // model: remaining stall cycles and a pending flush cycle, per instance
    int lu [2] = '{1, 3};
    int m_left [2] = '{0, 0};
    bit m_flush [2] = '{0, 0};

    always #5 clk = ~clk;

    hazard_ctrl #(.LU_STALL(1), .XLEN_PC(12)) u0 (
        .clk(clk), .rst(rst), .i_d_rs1(d_rs1), .i_d_rs2(d_rs2), .i_ex_rd(ex_rd),
        .i_ex_memrd(ex_memrd), .i_ex_br_taken(ex_br_taken), .i_ex_br_target(ex_br_target),
        .i_halt_req(halt_req), .o_f_pcwr(pcwr[0]), .o_f_pcsrc(pcsrc[0]), .o_f_pc_in(pcin[0]),
        .o_d_flush(dfl[0]), .o_e_bubble(bub[0])
`ifdef HAZARD_CTRL_PERF_EN
        , .o_stall_cnt(scnt[0]), .o_flush_cnt(fcnt[0])
`endif
    );

    hazard_ctrl #(.LU_STALL(3), .XLEN_PC(12)) u1 (
        .clk(clk), .rst(rst), .i_d_rs1(d_rs1), .i_d_rs2(d_rs2), .i_ex_rd(ex_rd),
        .i_ex_memrd(ex_memrd), .i_ex_br_taken(ex_br_taken), .i_ex_br_target(ex_br_target),
        .i_halt_req(halt_req), .o_f_pcwr(pcwr[1]), .o_f_pcsrc(pcsrc[1]), .o_f_pc_in(pcin[1]),
        .o_d_flush(dfl[1]), .o_e_bubble(bub[1])
`ifdef HAZARD_CTRL_PERF_EN
        , .o_stall_cnt(scnt[1]), .o_flush_cnt(fcnt[1])
`endif
    );

    task automatic chk(input string tag, input int k, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[lu=%0d] got %h exp %h", tag, lu[k], got, exp);
        end
    endtask

    task automatic step(input bit r, input bit br, input logic [11:0] tgt, input bit h,
                        input bit mr, input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        bit hit, e_wr, e_src, e_fl, e_bub;
        logic [11:0] e_pc;
        @(negedge clk);
        rst = r; ex_br_taken = br; ex_br_target = tgt; halt_req = h;
        ex_memrd = mr; ex_rd = rd; d_rs1 = s1; d_rs2 = s2;
        #1;
        hit = mr && rd != 0 && (rd == s1 || rd == s2);
        for (int k = 0; k < 2; k++) begin
            e_wr = 0; e_src = 0; e_fl = 0; e_bub = 0; e_pc = '0;
            if (r) begin
                m_left[k] = 0; m_flush[k] = 0;
            end else if (br) begin
                e_src = 1; e_pc = tgt; e_fl = 1;
                m_left[k] = 0; m_flush[k] = 1;
            end else if (h) begin
                e_wr = 1; e_bub = 1; e_fl = m_flush[k];
                m_left[k] = 0; m_flush[k] = 0;
            end else if (m_flush[k]) begin
                e_fl = 1; e_bub = 1; m_flush[k] = 0;
            end else if (m_left[k] > 0) begin
                e_wr = 1; e_bub = 1; m_left[k]--;
            end else if (hit) begin
                e_wr = 1; e_bub = 1; m_left[k] = lu[k] - 1;
            end
            chk("f_pcwr", k, 16'(pcwr[k]), 16'(e_wr));
            chk("f_pcsrc", k, 16'(pcsrc[k]), 16'(e_src));
            chk("f_pc_in", k, 16'(pcin[k]), 16'(e_pc));
            chk("d_flush", k, 16'(dfl[k]), 16'(e_fl));
            chk("e_bubble", k, 16'(bub[k]), 16'(e_bub));
            chk("pcwr_and_pcsrc", k, 16'(pcwr[k] & pcsrc[k]), 16'd0);
`ifdef HAZARD_CTRL_PERF_EN
            chk("stall_cnt", k, scnt[k], 16'(m_scnt[k]));
            chk("flush_cnt", k, fcnt[k], 16'(m_fcnt[k]));
            if (r) begin
                m_scnt[k] = 0; m_fcnt[k] = 0;
            end else begin
                if (e_wr && m_scnt[k] < 16'hFFFF) m_scnt[k]++;
                if (e_src && m_fcnt[k] < 16'hFFFF) m_fcnt[k]++;
            end
`endif
        end
    endtask

    initial begin
        // reset and idle
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 12'hABC, 1, 1, 5, 5, 5);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // branch redirect then one flush cycle
        step(0, 1, 12'h040, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // load-use hit via rs2
        step(0, 0, 0, 0, 1, 5, 1, 5);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // branch in the 2nd stall cycle aborts the stall
        step(0, 0, 0, 0, 1, 7, 7, 2);
        step(0, 1, 12'h123, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // hit and branch together
        step(0, 1, 12'hFFF, 0, 1, 3, 3, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // halt held 4 cycles during a stall
        step(0, 0, 0, 0, 1, 9, 9, 0);
        repeat (4) step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // reset pulsed in HALT
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // ex_rd=0 never stalls
        step(0, 0, 0, 0, 1, 0, 0, 0);
        // branch during halt, branch during flush, halt during flush
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 12'h555, 1, 0, 0, 0, 0);
        step(0, 1, 12'h2AA, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4, 4, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // reset mid-stall
        step(0, 0, 0, 0, 1, 6, 0, 6);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_CTRL_PERF_EN
        // two stalls and one branch on the LU=1 instance after reset
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 0, 5);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 12'h010, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_cnt_two", 0, scnt[0], 16'd2);
        chk("flush_cnt_one", 0, fcnt[0], 16'd1);
        // saturation
        @(negedge clk);
        force u0.r_stall_cnt = 16'hFFFF;
        force u0.r_flush_cnt = 16'hFFFF;
        force u1.r_stall_cnt = 16'hFFFF;
        force u1.r_flush_cnt = 16'hFFFF;
        #1;
        release u0.r_stall_cnt;
        release u0.r_flush_cnt;
        release u1.r_stall_cnt;
        release u1.r_flush_cnt;
        for (int k = 0; k < 2; k++) begin
            m_scnt[k] = 16'hFFFF; m_fcnt[k] = 16'hFFFF;
        end
        step(0, 0, 0, 0, 1, 8, 8, 8);
        step(0, 1, 12'h001, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
`endif
        // random traffic
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0, 12'($urandom),
                 $urandom_range(0, 7) == 0, 1'($urandom), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LU_STALL, default 1; number of stall cycles per load-use hazard, range 1..3.
REQ-002 Parameter XLEN_PC, default 12; width of the instruction-word PC, matching the fetch stage.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 d_rs1, d_rs2  in  5 each  source registers of the instruction in decode.
REQ-006 ex_rd  in  5  destination register of the instruction in execute.
REQ-007 ex_memrd  in  1  the execute-stage instruction is a load.
REQ-008 ex_br_taken  in  1  the execute stage resolved a taken branch or jump.
REQ-009 ex_br_target  in  XLEN_PC  redirect target word address.
REQ-010 halt_req  in  1  external hold request (debug or memory wait).
REQ-011 f_pcwr  out  1  fetch hold: PC and fetch outputs frozen.
REQ-012 f_pcsrc  out  1  fetch redirect strobe.
REQ-013 f_pc_in  out  XLEN_PC  redirect target; equals ex_br_target while f_pcsrc=1, else 0.
REQ-014 d_flush  out  1  kill the instruction in the fetch/decode register.
REQ-015 e_bubble  out  1  insert a NOP into the execute stage.

Function
REQ-016 The FSM SHALL have states RUN, STALL, FLUSH and HALT, plus a 2-bit stall counter scnt.
REQ-017 Load-use hit: ex_memrd=1 and ex_rd!=0 and (ex_rd==d_rs1 or ex_rd==d_rs2).
REQ-018 Outputs SHALL be combinational from the state and the current inputs, with zero-cycle latency to the fetch stage.
REQ-019 Priority, highest first: rst, ex_br_taken, halt_req, load-use hit.
REQ-020 RUN with ex_br_taken: f_pcsrc=1, f_pc_in=ex_br_target, d_flush=1 this cycle; next state FLUSH.
REQ-021 FLUSH: d_flush=1 and e_bubble=1 for exactly one cycle; next state RUN, and a branch arriving here is handled as in REQ-020.
REQ-022 RUN with load-use hit: f_pcwr=1 and e_bubble=1 this cycle; scnt loads LU_STALL-1; next state STALL if LU_STALL>1, else RUN.
REQ-023 STALL: f_pcwr=1 and e_bubble=1; scnt decrements; exit to RUN in the cycle after scnt reaches 0.
REQ-024 A branch taken while in STALL SHALL abort the stall: redirect per REQ-020, f_pcwr=0, and scnt is cleared.
REQ-025 halt_req=1 in RUN, STALL or FLUSH (with no branch): f_pcwr=1 and e_bubble=1; next state HALT, and the STALL residue is discarded.
REQ-026 HALT: f_pcwr=1 and e_bubble=1 while halt_req=1; on deassertion, return to RUN.
REQ-027 A branch taken while in HALT SHALL still redirect, then enter FLUSH.
REQ-028 f_pcwr and f_pcsrc SHALL never be asserted in the same cycle.
REQ-029 In RUN with no event, all outputs SHALL be 0.
REQ-030 ex_rd=0 SHALL never cause a stall.

Reset
REQ-031 While rst=1, all outputs SHALL be 0 combinationally; state=RUN and scnt=0 after the edge.
REQ-032 Reset asserted mid-STALL, FLUSH or HALT SHALL abandon the sequence, with RUN on the following cycle.
REQ-033 Performance counters, when present, SHALL clear to 0 on reset.

Configuration
REQ-034 Macro HAZARD_CTRL_PERF_EN, when defined, adds outputs stall_cnt[15:0] and flush_cnt[15:0].
REQ-035 With the macro defined, stall_cnt increments on each cycle with f_pcwr=1, and flush_cnt increments on each f_pcsrc=1 cycle.
REQ-036 Both counters SHALL saturate at 16'hFFFF.
REQ-037 Without the macro, the counters and their ports SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-038 ex_memrd=1, ex_rd=5, d_rs2=5, LU_STALL=1 -> one cycle of f_pcwr=1 and e_bubble=1, then RUN with all outputs 0.
REQ-039 LU_STALL=3 with a hit -> f_pcwr=1 for exactly 3 cycles; ex_br_taken in the 2nd cycle -> f_pcsrc=1, f_pc_in=target, f_pcwr=0, then one FLUSH cycle.
REQ-040 ex_br_taken=1, ex_br_target=12'h040 -> same cycle f_pcsrc=1, f_pc_in=12'h040, d_flush=1; next cycle d_flush=1, e_bubble=1; then all 0.
REQ-041 Load-use hit and ex_br_taken in the same cycle -> redirect only, with f_pcwr=0.
REQ-042 halt_req held 4 cycles during STALL -> f_pcwr=1 for all 4 cycles, then RUN; rst pulsed in HALT -> outputs 0 and RUN.
REQ-043 With HAZARD_CTRL_PERF_EN defined: 2 stalls and 1 branch -> stall_cnt=2, flush_cnt=1; forcing counters to 16'hFFFF -> they hold at 16'hFFFF.
